// File: rtl/svnet_ram_fifo_mc.sv
// Multi-channel circular FIFO: CHANNELS queues of DEPTH words each, sharing one
// simple-dual-port RAM, with one write and one read per cycle steered by channel.
module svnet_ram_fifo_mc #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 1,
  parameter int CHANNELS = 1,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [CHANNELS*CW-1:0] free_space,
  output logic [CHANNELS*CW-1:0] used_space,
  input  logic                   write,
  input  logic [CHW-1:0]         write_channel,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   read,
  input  logic [CHW-1:0]         read_channel,
  output logic                   read_valid,
  output logic [CHW-1:0]         read_valid_channel,
  output logic [WIDTH-1:0]       read_data,
  input  logic                   flush,
  input  logic [CHW-1:0]         flush_channel,
  output logic                   error
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORDS = CHANNELS * DEPTH;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Request semantics: write/read/flush are single-cycle strobes with no
  // back-pressure. A request is accepted when its channel is in range and the
  // channel has room (write) or data (read) as sampled at the edge; otherwise
  // it is dropped and error latches. read_valid pulses exactly one cycle later.

  logic [WIDTH-1:0]    mem  [WORDS];
  logic [PW-1:0]       wptr [CHANNELS];
  logic [PW-1:0]       rptr [CHANNELS];
  logic [CW-1:0]       used [CHANNELS];

  logic                wc_ok, rc_ok, fc_ok;
  int                  wc_s, rc_s, fc_s;
  logic                fl_ok, wr_flushed, rd_flushed;
  logic                wr_legal, rd_legal, wr_go, rd_go;
  logic                wr_bad, rd_bad, fl_bad;
  logic [AW-1:0]       waddr, raddr;
  logic [CHANNELS-1:0] wr_hit, rd_hit, fl_hit;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wc_ok = int'(write_channel) < CHANNELS;
    rc_ok = int'(read_channel) < CHANNELS;
    fc_ok = int'(flush_channel) < CHANNELS;
    // Out-of-range indices are folded to 0 so array lookups stay in bounds;
    // such requests are never legal, so the folded value is never acted on.
    wc_s  = wc_ok ? int'(write_channel) : 0;
    rc_s  = rc_ok ? int'(read_channel) : 0;
    fc_s  = fc_ok ? int'(flush_channel) : 0;

    fl_ok      = flush && fc_ok;
    wr_flushed = fl_ok && (flush_channel == write_channel);
    rd_flushed = fl_ok && (flush_channel == read_channel);

    wr_legal = write && wc_ok && (used[wc_s] != CW'(DEPTH));
    rd_legal = read && rc_ok && (used[rc_s] != '0);
    wr_go    = wr_legal && !wr_flushed;
    rd_go    = rd_legal && !rd_flushed;

    wr_bad = write && !wr_legal && !wr_flushed;
    rd_bad = read && !rd_legal && !rd_flushed;
    fl_bad = flush && !fc_ok;

    waddr = AW'(wc_s * DEPTH + int'(wptr[wc_s]));
    raddr = AW'(rc_s * DEPTH + int'(rptr[rc_s]));

    wr_hit = '0;
    rd_hit = '0;
    fl_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = wr_go && (wc_s == c);
      rd_hit[c] = rd_go && (rc_s == c);
      fl_hit[c] = fl_ok && (fc_s == c);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) mem[waddr] <= write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        used[c] <= '0;
      end
      read_valid         <= 1'b0;
      read_valid_channel <= '0;
      read_data          <= '0;
      error              <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (fl_hit[c]) begin
          wptr[c] <= '0;
          rptr[c] <= '0;
          used[c] <= '0;
        end else begin
          if (wr_hit[c]) wptr[c] <= bump(wptr[c]);
          if (rd_hit[c]) rptr[c] <= bump(rptr[c]);
          case ({wr_hit[c], rd_hit[c]})
            2'b10:   used[c] <= used[c] + CW'(1);
            2'b01:   used[c] <= used[c] - CW'(1);
            default: used[c] <= used[c];
          endcase
        end
      end
      read_valid <= rd_go;
      if (rd_go) begin
        read_data          <= mem[raddr];
        read_valid_channel <= read_channel;
      end
      error <= error | wr_bad | rd_bad | fl_bad;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign used_space[g*CW +: CW] = used[g];
    assign free_space[g*CW +: CW] = CW'(DEPTH) - used[g];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(wr_bad || rd_bad || fl_bad))
        else $warning("svnet_ram_fifo_mc: illegal request dropped");
    end
  end

endmodule

// File: tb/tb_svnet_ram_fifo_mc.sv
// Bench for svnet_ram_fifo_mc (WIDTH=8, DEPTH=4, CHANNELS=3): directed vector
// table, corner-case sequences and random traffic against a queue-based model.
module tb_svnet_ram_fifo_mc;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NCH   = 3;
  localparam int CW    = 3;
  localparam int CHW   = 2;

  logic                clk;
  logic                rst_n;
  logic [NCH*CW-1:0]   free_space;
  logic [NCH*CW-1:0]   used_space;
  logic                write;
  logic [CHW-1:0]      write_channel;
  logic [WIDTH-1:0]    write_data;
  logic                read;
  logic [CHW-1:0]      read_channel;
  logic                read_valid;
  logic [CHW-1:0]      read_valid_channel;
  logic [WIDTH-1:0]    read_data;
  logic                flush;
  logic [CHW-1:0]      flush_channel;
  logic                error;

  svnet_ram_fifo_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .free_space(free_space), .used_space(used_space),
    .write(write), .write_channel(write_channel), .write_data(write_data),
    .read(read), .read_channel(read_channel),
    .read_valid(read_valid), .read_valid_channel(read_valid_channel),
    .read_data(read_data),
    .flush(flush), .flush_channel(flush_channel),
    .error(error)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch=%0d actual=%0h expected=%0h", name, ch, act, exp);
    end
  endtask

  // reference model: one queue per channel plus the output registers
  logic [WIDTH-1:0] mq [NCH][$];
  logic             m_rv;
  logic [CHW-1:0]   m_rvc;
  logic [WIDTH-1:0] m_rd;
  logic             m_err;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_rv  = 1'b0;
    m_rvc = '0;
    m_rd  = '0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit w, input int wc, input logic [WIDTH-1:0] wd,
                            input bit r, input int rc, input bit f, input int fc);
    bit fl_ok, wr_do, rd_do, bad;
    fl_ok = f && (fc < NCH);
    wr_do = 0;
    rd_do = 0;
    bad   = f && (fc >= NCH);
    if (w) begin
      if (wc >= NCH) bad = 1;
      else if (!(fl_ok && fc == wc)) begin
        if (mq[wc].size() < DEPTH) wr_do = 1;
        else bad = 1;
      end
    end
    if (r) begin
      if (rc >= NCH) bad = 1;
      else if (!(fl_ok && fc == rc)) begin
        if (mq[rc].size() > 0) rd_do = 1;
        else bad = 1;
      end
    end
    m_rv = rd_do;
    if (rd_do) begin
      m_rd  = mq[rc].pop_front();
      m_rvc = CHW'(rc);
    end
    if (wr_do) mq[wc].push_back(wd);
    if (fl_ok) mq[fc].delete();
    if (bad) m_err = 1'b1;
  endtask

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      chk("used_space", c, 32'(used_space[c*CW +: CW]), 32'(mq[c].size()));
      chk("free_space", c, 32'(free_space[c*CW +: CW]), 32'(DEPTH - mq[c].size()));
    end
    chk("error", 0, 32'(error), 32'(m_err));
    chk("read_valid", 0, 32'(read_valid), 32'(m_rv));
    chk("read_valid_channel", 0, 32'(read_valid_channel), 32'(m_rvc));
    chk("read_data", 0, 32'(read_data), 32'(m_rd));
  endtask

  // driver: one clock cycle of requests, checked just after the edge
  task automatic cycle(input bit w, input int wc, input logic [WIDTH-1:0] wd,
                       input bit r, input int rc, input bit f, input int fc);
    write         = w;
    write_channel = CHW'(wc);
    write_data    = wd;
    read          = r;
    read_channel  = CHW'(rc);
    flush         = f;
    flush_channel = CHW'(fc);
    model_step(w, wc, wd, r, rc, f, fc);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic reset_dut();
    write = 1'b0; read = 1'b0; flush = 1'b0;
    write_channel = '0; read_channel = '0; flush_channel = '0; write_data = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit w; int wc; logic [WIDTH-1:0] wd;
    bit r; int rc; bit f; int fc;
    int u0, u1, u2;
    bit rv; int rvc; logic [WIDTH-1:0] rd; bit err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit w, int wc, logic [WIDTH-1:0] wd, bit r, int rc, bit f, int fc,
                              int u0, int u1, int u2, bit rv, int rvc, logic [WIDTH-1:0] rd, bit err);
    vec_t v;
    v.w = w; v.wc = wc; v.wd = wd; v.r = r; v.rc = rc; v.f = f; v.fc = fc;
    v.u0 = u0; v.u1 = u1; v.u2 = u2; v.rv = rv; v.rvc = rvc; v.rd = rd; v.err = err;
    return v;
  endfunction

  initial begin
    // basic: three words through channel 1
    tbl.push_back(mk(1,1,8'h11, 0,0, 0,0, 0,1,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,1,8'h22, 0,0, 0,0, 0,2,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,1,8'h33, 0,0, 0,0, 0,3,0, 0,0,8'h00, 0));
    tbl.push_back(mk(0,0,8'h00, 1,1, 0,0, 0,2,0, 1,1,8'h11, 0));
    tbl.push_back(mk(0,0,8'h00, 1,1, 0,0, 0,1,0, 1,1,8'h22, 0));
    tbl.push_back(mk(0,0,8'h00, 1,1, 0,0, 0,0,0, 1,1,8'h33, 0));
    // wrap and full on channel 2
    tbl.push_back(mk(1,2,8'h01, 0,0, 0,0, 0,0,1, 0,0,8'h00, 0));
    tbl.push_back(mk(1,2,8'h02, 0,0, 0,0, 0,0,2, 0,0,8'h00, 0));
    tbl.push_back(mk(1,2,8'h03, 0,0, 0,0, 0,0,3, 0,0,8'h00, 0));
    tbl.push_back(mk(1,2,8'h04, 0,0, 0,0, 0,0,4, 0,0,8'h00, 0));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,3, 1,2,8'h01, 0));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,2, 1,2,8'h02, 0));
    tbl.push_back(mk(1,2,8'hA0, 0,0, 0,0, 0,0,3, 0,0,8'h00, 0));
    tbl.push_back(mk(1,2,8'hB0, 0,0, 0,0, 0,0,4, 0,0,8'h00, 0));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,3, 1,2,8'h03, 0));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,2, 1,2,8'h04, 0));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,1, 1,2,8'hA0, 0));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,0, 1,2,8'hB0, 0));
    // simultaneous write/read, same and different channels
    tbl.push_back(mk(1,0,8'hC1, 0,0, 0,0, 1,0,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,0,8'hC2, 0,0, 0,0, 2,0,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,0,8'hC3, 1,0, 0,0, 2,0,0, 1,0,8'hC1, 0));
    tbl.push_back(mk(1,1,8'hD1, 0,0, 0,0, 2,1,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,0,8'hC4, 1,1, 0,0, 3,0,0, 1,1,8'hD1, 0));
    // flush channel 1 with a same-cycle read; pointers restart at 0
    tbl.push_back(mk(1,1,8'hE1, 0,0, 0,0, 3,1,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,1,8'hE2, 0,0, 0,0, 3,2,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,1,8'hE3, 0,0, 0,0, 3,3,0, 0,0,8'h00, 0));
    tbl.push_back(mk(0,0,8'h00, 1,1, 1,1, 3,0,0, 0,0,8'h00, 0));
    tbl.push_back(mk(1,1,8'hF1, 0,0, 0,0, 3,1,0, 0,0,8'h00, 0));
    tbl.push_back(mk(0,0,8'h00, 1,1, 0,0, 3,0,0, 1,1,8'hF1, 0));
    tbl.push_back(mk(0,0,8'h00, 1,0, 0,0, 2,0,0, 1,0,8'hC2, 0));
    tbl.push_back(mk(0,0,8'h00, 1,0, 0,0, 1,0,0, 1,0,8'hC3, 0));
    tbl.push_back(mk(0,0,8'h00, 1,0, 0,0, 0,0,0, 1,0,8'hC4, 0));
    // illegal: read empty, then write full channel 2
    tbl.push_back(mk(0,0,8'h00, 1,0, 0,0, 0,0,0, 0,0,8'h00, 1));
    tbl.push_back(mk(0,0,8'h00, 0,0, 0,0, 0,0,0, 0,0,8'h00, 1));
    tbl.push_back(mk(1,2,8'h51, 0,0, 0,0, 0,0,1, 0,0,8'h00, 1));
    tbl.push_back(mk(1,2,8'h52, 0,0, 0,0, 0,0,2, 0,0,8'h00, 1));
    tbl.push_back(mk(1,2,8'h53, 0,0, 0,0, 0,0,3, 0,0,8'h00, 1));
    tbl.push_back(mk(1,2,8'h54, 0,0, 0,0, 0,0,4, 0,0,8'h00, 1));
    tbl.push_back(mk(1,2,8'h99, 0,0, 0,0, 0,0,4, 0,0,8'h00, 1));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,3, 1,2,8'h51, 1));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,2, 1,2,8'h52, 1));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,1, 1,2,8'h53, 1));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,0, 1,2,8'h54, 1));
    tbl.push_back(mk(0,0,8'h00, 1,2, 0,0, 0,0,0, 0,0,8'h00, 1));

    reset_dut();

    foreach (tbl[i]) begin
      cycle(tbl[i].w, tbl[i].wc, tbl[i].wd, tbl[i].r, tbl[i].rc, tbl[i].f, tbl[i].fc);
      chk("tbl_used0", i, 32'(used_space[0*CW +: CW]), 32'(tbl[i].u0));
      chk("tbl_used1", i, 32'(used_space[1*CW +: CW]), 32'(tbl[i].u1));
      chk("tbl_used2", i, 32'(used_space[2*CW +: CW]), 32'(tbl[i].u2));
      chk("tbl_read_valid", i, 32'(read_valid), 32'(tbl[i].rv));
      chk("tbl_error", i, 32'(error), 32'(tbl[i].err));
      if (tbl[i].rv) begin
        chk("tbl_read_data", i, 32'(read_data), 32'(tbl[i].rd));
        chk("tbl_read_channel", i, 32'(read_valid_channel), 32'(tbl[i].rvc));
      end
    end

    // out-of-range channel on each request type
    reset_dut();
    cycle(1, 3, 8'h77, 0, 0, 0, 0);
    chk("ch3_write_err", 3, 32'(error), 32'd1);
    chk("ch3_write_used", 3, 32'(used_space), 32'd0);
    reset_dut();
    cycle(0, 0, 8'h00, 1, 3, 0, 0);
    chk("ch3_read_err", 3, 32'(error), 32'd1);
    chk("ch3_read_valid", 3, 32'(read_valid), 32'd0);
    reset_dut();
    cycle(0, 0, 8'h00, 0, 0, 1, 3);
    chk("ch3_flush_err", 3, 32'(error), 32'd1);

    // flush beats a same-cycle write on a full channel without error
    reset_dut();
    for (int k = 0; k < DEPTH; k++) cycle(1, 0, 8'(8'h60 + k), 0, 0, 0, 0);
    cycle(1, 0, 8'h6F, 0, 0, 1, 0);
    chk("flush_full_err", 0, 32'(error), 32'd0);
    chk("flush_full_free", 0, 32'(free_space[0 +: CW]), 32'd4);

    // async reset while a read_valid is pending
    reset_dut();
    cycle(1, 0, 8'h5A, 0, 0, 0, 0);
    cycle(1, 3, 8'h00, 0, 0, 0, 0);
    cycle(0, 0, 8'h00, 1, 0, 0, 0);
    chk("pre_reset_valid", 0, 32'(read_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("reset_valid", 0, 32'(read_valid), 32'd0);
    chk("reset_error", 0, 32'(error), 32'd0);
    chk("reset_free", 0, 32'(free_space), {23'd0, 3'd4, 3'd4, 3'd4});
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic, with periodic resets to re-arm the sticky error
    for (int n = 0; n < 600; n++) begin
      int wc, rc, fc;
      if (n % 100 == 0) reset_dut();
      wc = ($urandom_range(0, 39) == 0) ? 3 : $urandom_range(0, NCH - 1);
      rc = ($urandom_range(0, 39) == 0) ? 3 : $urandom_range(0, NCH - 1);
      fc = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, NCH - 1);
      cycle(1'($urandom_range(0, 1)), wc, 8'($urandom),
            1'($urandom_range(0, 1)), rc,
            ($urandom_range(0, 15) == 0), fc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
